// File: rtl/uart_rx.sv
// UART receiver: samples rxd on edges of a 16x sample strobe (sclk). It checks
// the start bit at mid-bit, shifts data in LSB first, and reports a good byte or a framing error.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 rxd_meta_r, rxd_sync_r;
  logic                 sclk_meta_r, sclk_sync_r, sclk_hist_r;
  logic                 rxd_s;
  logic                 tick_s;

  // Two-flop synchronizers for rxd and sclk, plus sclk edge history
  always_ff @(posedge clkin) begin
    if (rst) begin
      rxd_meta_r  <= 1'b1;
      rxd_sync_r  <= 1'b1;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_hist_r <= 1'b0;
    end else begin
      rxd_meta_r  <= rxd;
      rxd_sync_r  <= rxd_meta_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_hist_r <= sclk_sync_r;
    end
  end

  assign rxd_s   = rxd_sync_r;
  assign tick_s  = sclk_sync_r & ~sclk_hist_r;
  assign rx_busy = (state_r != ST_IDLE);

  // Receive FSM; it advances only on sample ticks, and the output pulses are registered
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_r     <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      rx_data   <= {DATA_BITS{1'b0}};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_r <= ST_START;
              cnt_r   <= {CW{1'b0}};
            end
          end
          ST_START: begin
            // Mid-bit check filters out short low glitches
            if (cnt_r == HALF) begin
              cnt_r <= {CW{1'b0}};
              if (!rxd_s) begin
                state_r <= ST_DATA;
                bit_r   <= {BW{1'b0}};
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_DATA: begin
            if (cnt_r == LAST) begin
              shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
              cnt_r   <= {CW{1'b0}};
              bit_r   <= bit_r + BW'(1);
              if (bit_r == LAST_BIT) begin
                state_r <= ST_STOP;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_STOP: begin
            if (cnt_r == LAST) begin
              cnt_r <= {CW{1'b0}};
              if (rxd_s) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
                state_r  <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state_r   <= ST_BRK;
              end
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_BRK: begin
            // Hold off until the line returns high, so a break is not read as new frames
            if (rxd_s) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: good frames, a glitch, a framing
// error with break, back-to-back frames, a mid-frame reset, and real divider timing.
module tb_uart_rx;

  logic       clkin = 1'b0;
  logic       rst   = 1'b1;
  logic       sclk  = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor state
  int         vcount    = 0;
  int         fcount    = 0;
  int         width_err = 0;
  int         both_err  = 0;
  int         busy_err  = 0;
  logic       prev_v    = 1'b0;
  logic       prev_f    = 1'b0;
  logic [7:0] caps[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .sclk     (sclk),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 clkin = ~clkin;

  // Samples the outputs on the falling edge and records each pulse
  always @(negedge clkin) begin
    if (rx_valid) begin
      vcount = vcount + 1;
      caps.push_back(rx_data);
      if (rx_busy) busy_err = busy_err + 1;
    end
    if (frame_err) fcount = fcount + 1;
    if ((rx_valid && prev_v) || (frame_err && prev_f)) width_err = width_err + 1;
    if (rx_valid && frame_err) both_err = both_err + 1;
    prev_v = rx_valid;
    prev_f = frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample period of 8 clkin cycles with rxd held at v
  task automatic tick_once(input logic v);
    @(negedge clkin);
    rxd  = v;
    sclk = 1'b1;
    repeat (4) @(negedge clkin);
    sclk = 1'b0;
    repeat (3) @(negedge clkin);
  endtask

  task automatic ticks(input logic v, input int n);
    for (int i = 0; i < n; i++) tick_once(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    ticks(1'b0, 16);
    for (int b = 0; b < 8; b++) ticks(d[b], 16);
    ticks(stop, 16);
  endtask

  task automatic pulse_rst();
    @(negedge clkin);
    rst = 1'b1;
    @(negedge clkin);
    rst = 1'b0;
  endtask

  int         v0;
  int         f0;
  logic [7:0] div_byte;
  logic       line_bits[0:10];

  initial begin
    repeat (4) @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    check_eq("reset_data",  {24'd0, rx_data}, 32'h0);
    check_eq("reset_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("reset_ferr",  {31'd0, frame_err}, 32'h0);
    check_eq("reset_busy",  {31'd0, rx_busy}, 32'h0);

    // Good frame 0xA5
    ticks(1'b1, 4);
    send_frame(8'hA5, 1'b1);
    ticks(1'b1, 4);
    check_eq("a5_valid_cnt", vcount, 32'd1);
    check_eq("a5_data", {24'd0, caps[0]}, 32'hA5);
    check_eq("a5_ferr_cnt", fcount, 32'd0);
    check_eq("a5_busy_idle", {31'd0, rx_busy}, 32'h0);

    // Low glitch of 4 ticks
    ticks(1'b0, 4);
    check_eq("glitch_busy_mid", {31'd0, rx_busy}, 32'h1);
    ticks(1'b1, 20);
    check_eq("glitch_busy_end", {31'd0, rx_busy}, 32'h0);
    check_eq("glitch_valid_cnt", vcount, 32'd1);
    check_eq("glitch_ferr_cnt", fcount, 32'd0);
    check_eq("glitch_data_kept", {24'd0, rx_data}, 32'hA5);

    // 0x3C with a low stop bit, then a break
    send_frame(8'h3C, 1'b0);
    ticks(1'b0, 40);
    check_eq("ferr_cnt", fcount, 32'd1);
    check_eq("ferr_valid_cnt", vcount, 32'd1);
    check_eq("ferr_data_kept", {24'd0, rx_data}, 32'hA5);
    check_eq("ferr_busy_break", {31'd0, rx_busy}, 32'h1);
    tick_once(1'b1);
    check_eq("ferr_busy_release", {31'd0, rx_busy}, 32'h0);
    ticks(1'b1, 20);
    check_eq("ferr_cnt_after", fcount, 32'd1);

    // Back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    ticks(1'b1, 4);
    check_eq("b2b_valid_cnt", vcount, 32'd3);
    check_eq("b2b_first", {24'd0, caps[1]}, 32'h00);
    check_eq("b2b_second", {24'd0, caps[2]}, 32'hFF);

    // Reset during data bit 4 of 0x55, then a clean 0x81
    ticks(1'b1, 4);
    ticks(1'b0, 16);
    for (int b = 0; b < 4; b++) ticks(b[0] ? 1'b0 : 1'b1, 16);
    ticks(1'b1, 8);
    check_eq("rst_busy_before", {31'd0, rx_busy}, 32'h1);
    pulse_rst();
    check_eq("rst_mid_data", {24'd0, rx_data}, 32'h0);
    check_eq("rst_mid_valid", {31'd0, rx_valid}, 32'h0);
    check_eq("rst_mid_ferr", {31'd0, frame_err}, 32'h0);
    check_eq("rst_mid_busy", {31'd0, rx_busy}, 32'h0);
    ticks(1'b1, 20);
    check_eq("rst_no_valid", vcount, 32'd3);
    send_frame(8'h81, 1'b1);
    ticks(1'b1, 4);
    check_eq("rst_next_cnt", vcount, 32'd4);
    check_eq("rst_next_data", {24'd0, caps[3]}, 32'h81);

    // Real divider: sclk period 326 cycles, bit period 16*326 cycles
    div_byte = 8'h7E;
    line_bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) line_bits[b+1] = div_byte[b];
    line_bits[9]  = 1'b1;
    line_bits[10] = 1'b1;
    for (int c = 0; c < 11 * 5216; c++) begin
      @(negedge clkin);
      sclk = ((c % 326) < 163);
      rxd  = line_bits[c / 5216];
    end
    check_eq("div_valid_cnt", vcount, 32'd5);
    check_eq("div_data", {24'd0, caps[4]}, 32'h7E);
    check_eq("div_busy_idle", {31'd0, rx_busy}, 32'h0);

    check_eq("pulse_width_errs", width_err, 32'd0);
    check_eq("pulse_overlap_errs", both_err, 32'd0);
    check_eq("busy_at_valid_errs", busy_err, 32'd0);
    check_eq("total_ferr", fcount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
